handshake_constant_seq: RTL and testbench

- Parametrised successor of the fixed-value handshake constant source.
- Each accepted control token produces exactly one output token, carrying either a fixed constant (MODE_CONST) or a wrapping arithmetic sequence (MODE_SEQ).
- An internal token-occupancy buffer of depth DEPTH decouples the channels, so ctrl_ready does not combinationally depend on outs_ready.
- Sits in the dataflow fabric wherever a constant or induction-style value is triggered by a control token.

---
 rtl/handshake_pkg.sv | 15 +
 rtl/handshake_token_counter.sv | 28 ++
 rtl/handshake_constant_seq.sv | 55 +++++
 tb/tb_handshake_constant_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// handshake_pkg: shared mode codes and width helpers for the handshake constant/sequence source
package handshake_pkg;
  localparam int MODE_CONST = 0;
  localparam int MODE_SEQ = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction
  // Occupancy counters must represent 0..DEPTH inclusive
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction
endpackage

// File: rtl/handshake_token_counter.sv
// handshake_token_counter: token occupancy counter decoupling the ctrl and outs handshakes
module handshake_token_counter
  import handshake_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctrl_valid,
  input  logic          outs_ready,
  output logic          ctrl_ready,
  output logic          outs_valid,
  output logic          emit,
  output logic [CW-1:0] pending
);
  logic [CW-1:0] count_q, count_d;
  logic accept;
  assign ctrl_ready = count_q != CW'(DEPTH);
  assign outs_valid = count_q != '0;
  assign accept = ctrl_valid & ctrl_ready;
  assign emit = outs_valid & outs_ready;
  assign count_d = count_q + CW'(accept) - CW'(emit);
  assign pending = count_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq: emits one constant or sequence value per accepted control token
module handshake_constant_seq
  import handshake_pkg::*;
#(
  parameter int     DATA_WIDTH = 32,
  parameter int     MODE       = MODE_CONST,
  parameter longint BASE_VALUE = 0,
  parameter longint STEP       = 1,
  parameter int     WRAP_COUNT = 0,
  parameter int     DEPTH      = 2,
  localparam int    CW         = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CW-1:0]         pending
);
  localparam logic [DATA_WIDTH-1:0] BASE = DATA_WIDTH'(BASE_VALUE);
  localparam logic [DATA_WIDTH-1:0] INC = DATA_WIDTH'(STEP);
  localparam int IW = WRAP_COUNT > 1 ? clog2(WRAP_COUNT) : 1;
  localparam logic [IW-1:0] LAST = IW'(WRAP_COUNT > 1 ? WRAP_COUNT - 1 : 0);
  localparam bit WRAP = WRAP_COUNT != 0;
  logic emit, wrap;
  logic [DATA_WIDTH-1:0] seq_q, seq_d;
  logic [IW-1:0] idx_q, idx_d;
  handshake_token_counter #(.DEPTH(DEPTH)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .outs_ready (outs_ready),
    .ctrl_ready (ctrl_ready),
    .outs_valid (outs_valid),
    .emit       (emit),
    .pending    (pending)
  );
  // Tokens are indistinguishable, so the sequence advances in emission order only
  always_comb begin
    wrap = WRAP && idx_q == LAST;
    idx_d = !emit ? idx_q : wrap ? '0 : idx_q + 1'b1;
    seq_d = !emit ? seq_q : wrap ? BASE : seq_q + INC;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      seq_q <= BASE;
      idx_q <= '0;
    end else begin
      seq_q <= seq_d;
      idx_q <= idx_d;
    end
  assign outs = MODE == MODE_SEQ ? seq_q : BASE;
endmodule

// File: tb/tb_handshake_constant_seq.sv
// tb_handshake_constant_seq: scoreboard bench covering const, wrap-sequence and negative-step instances
module tb_handshake_constant_seq;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic a_cv = 0, a_or = 0, a_cr, a_ov;
  logic [5:0] a_outs;
  logic [1:0] a_pend;
  logic b_cv = 0, b_or = 0, b_cr, b_ov;
  logic [7:0] b_outs;
  logic [1:0] b_pend;
  logic c_cv = 0, c_or = 0, c_cr, c_ov;
  logic [7:0] c_outs;
  logic [0:0] c_pend;
  int vectors = 0, miscompares = 0;
  int exp_a = 0;
  logic [7:0] sb[$];

  handshake_constant_seq #(.DATA_WIDTH(6), .MODE(0), .BASE_VALUE(23), .DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .ctrl_valid(a_cv), .ctrl_ready(a_cr), .outs(a_outs),
    .outs_valid(a_ov), .outs_ready(a_or), .pending(a_pend));
  handshake_constant_seq #(.DATA_WIDTH(8), .MODE(1), .BASE_VALUE(10), .STEP(3), .WRAP_COUNT(4), .DEPTH(2)) u_b (
    .clk(clk), .rst(rst), .ctrl_valid(b_cv), .ctrl_ready(b_cr), .outs(b_outs),
    .outs_valid(b_ov), .outs_ready(b_or), .pending(b_pend));
  handshake_constant_seq #(.DATA_WIDTH(8), .MODE(1), .BASE_VALUE(1), .STEP(-1), .WRAP_COUNT(0), .DEPTH(1)) u_c (
    .clk(clk), .rst(rst), .ctrl_valid(c_cv), .ctrl_ready(c_cr), .outs(c_outs),
    .outs_valid(c_ov), .outs_ready(c_or), .pending(c_pend));

  always @(negedge clk)
    if (rst && (a_pend > 2 || b_pend > 2)) begin
      miscompares++;
      $display("FAIL occupancy a_pend=%0d b_pend=%0d want <=2", a_pend, b_pend);
    end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic test_reset;
    rst = 0; a_cv = 1; b_cv = 1; c_cv = 1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({a_cr, a_ov, a_pend} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_a got cr=%b ov=%b pend=%0d want cr=1 ov=0 pend=0", a_cr, a_ov, a_pend);
    end
    vectors++;
    if ({b_cr, b_ov, b_pend} !== 4'b1000 || b_outs !== 8'd10) begin
      miscompares++;
      $display("FAIL reset_b got cr=%b ov=%b pend=%0d outs=%0d want 1 0 0 10", b_cr, b_ov, b_pend, b_outs);
    end
    vectors++;
    if ({c_cr, c_ov, c_pend} !== 3'b100 || c_outs !== 8'd1) begin
      miscompares++;
      $display("FAIL reset_c got cr=%b ov=%b pend=%0d outs=%0d want 1 0 0 1", c_cr, c_ov, c_pend, c_outs);
    end
    @(negedge clk);
    rst = 1; a_cv = 0; b_cv = 0; c_cv = 0;
    @(negedge clk);
    a_cv = 1; a_or = 0;
    repeat (2) @(negedge clk);
    a_cv = 0;
    #1;
    vectors++;
    if (a_pend !== 2'd2) begin
      miscompares++;
      $display("FAIL prefill got pend=%0d want 2", a_pend);
    end
    #2 rst = 0;
    #1;
    vectors++;
    if (a_ov !== 1'b0 || a_pend !== 2'd0 || a_cr !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset got ov=%b pend=%0d cr=%b want 0 0 1", a_ov, a_pend, a_cr);
    end
    @(negedge clk);
    rst = 1; exp_a = 0; sb.delete();
  endtask

  task automatic test_latency_const;
    bit acc, em;
    logic [7:0] e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_cv = (i == 0); a_or = 1;
      #1;
      acc = a_cv && exp_a != 2;
      em = exp_a != 0 && a_or;
      vectors++;
      if (a_ov !== (i == 1) || a_outs !== 6'b010111) begin
        miscompares++;
        $display("FAIL latency cyc=%0d got ov=%b outs=%0d want ov=%b outs=23", i, a_ov, a_outs, i == 1);
      end
      vectors++;
      if (a_pend !== 2'(exp_a) || a_cr !== (exp_a != 2)) begin
        miscompares++;
        $display("FAIL latency_cnt got pend=%0d cr=%b want pend=%0d", a_pend, a_cr, exp_a);
      end
      if (acc) sb.push_back(8'd23);
      if (em) begin
        e = sb.pop_front();
        vectors++;
        if ({2'b0, a_outs} !== e) begin
          miscompares++;
          $display("FAIL latency_data got %0d want %0d", a_outs, e);
        end
      end
      exp_a += int'(acc) - int'(em);
    end
  endtask

  task automatic test_backpressure;
    bit cvs[10] = '{1, 1, 1, 1, 0, 0, 1, 0, 0, 0};
    bit ors[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    bit acc, em;
    logic [7:0] e;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_cv = cvs[i]; a_or = ors[i];
      #1;
      acc = a_cv && exp_a != 2;
      em = exp_a != 0 && a_or;
      vectors++;
      if (a_pend !== 2'(exp_a) || a_cr !== (exp_a != 2) || a_ov !== (exp_a != 0)) begin
        miscompares++;
        $display("FAIL backpressure cyc=%0d got pend=%0d cr=%b ov=%b want pend=%0d", i, a_pend, a_cr, a_ov, exp_a);
      end
      if (acc) sb.push_back(8'd23);
      if (em) begin
        e = sb.pop_front();
        vectors++;
        if ({2'b0, a_outs} !== e) begin
          miscompares++;
          $display("FAIL backpressure_data got %0d want %0d", a_outs, e);
        end
      end
      exp_a += int'(acc) - int'(em);
    end
  endtask

  task automatic test_back_to_back;
    bit acc, em;
    int emits = 0;
    for (int i = 0; i < 102; i++) begin
      @(negedge clk);
      a_cv = (i < 101); a_or = 1;
      #1;
      acc = a_cv && exp_a != 2;
      em = exp_a != 0 && a_or;
      vectors++;
      if (a_pend !== 2'(exp_a) || a_cr !== (exp_a != 2) || a_ov !== (exp_a != 0)) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d got pend=%0d cr=%b ov=%b want pend=%0d", i, a_pend, a_cr, a_ov, exp_a);
      end
      if (acc) sb.push_back(8'd23);
      if (em) begin
        emits++;
        if (sb.pop_front() !== {2'b0, a_outs}) begin
          miscompares++;
          $display("FAIL back_to_back_data got %0d want 23", a_outs);
        end
      end
      exp_a += int'(acc) - int'(em);
    end
    a_cv = 0;
    vectors++;
    if (emits != 101 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL back_to_back_count got emits=%0d left=%0d want 101 0", emits, sb.size());
    end
  endtask

  task automatic test_seq_wrap;
    bit acc, em, hold = 0;
    int exp_b = 0, pushed = 0, popped = 0, cycles = 0, m_idx = 0;
    logic [7:0] m_val = 8'd10, prev = 0, e;
    while (popped < 10 && cycles < 300) begin
      @(negedge clk);
      b_cv = (pushed < 10); b_or = 1'($urandom_range(0, 1));
      #1;
      acc = b_cv && exp_b != 2;
      em = exp_b != 0 && b_or;
      if (hold) begin
        vectors++;
        if (b_ov !== 1'b1 || b_outs !== prev) begin
          miscompares++;
          $display("FAIL stall_stable got ov=%b outs=%0d want 1 %0d", b_ov, b_outs, prev);
        end
      end
      vectors++;
      if (b_pend !== 2'(exp_b) || b_ov !== (exp_b != 0)) begin
        miscompares++;
        $display("FAIL seq_cnt got pend=%0d ov=%b want pend=%0d", b_pend, b_ov, exp_b);
      end
      if (acc) begin
        sb.push_back(m_val);
        pushed++;
        m_idx++;
        if (m_idx == 4) begin
          m_idx = 0;
          m_val = 8'd10;
        end else m_val = m_val + 8'd3;
      end
      if (em) begin
        e = sb.pop_front();
        popped++;
        vectors++;
        if (b_outs !== e) begin
          miscompares++;
          $display("FAIL seq_data tok=%0d got %0d want %0d", popped, b_outs, e);
        end
      end
      hold = exp_b != 0 && !b_or;
      prev = b_outs;
      exp_b += int'(acc) - int'(em);
      cycles++;
    end
    b_cv = 0; b_or = 0;
    vectors++;
    if (popped != 10) begin
      miscompares++;
      $display("FAIL seq_timeout got %0d emits want 10", popped);
    end
  endtask

  task automatic test_neg_step;
    bit acc, em;
    int exp_c = 0, pushed = 0, popped = 0, cycles = 0;
    logic [7:0] m_val = 8'd1, e;
    while (popped < 3 && cycles < 20) begin
      @(negedge clk);
      c_cv = (pushed < 3); c_or = 1;
      #1;
      acc = c_cv && exp_c == 0;
      em = exp_c != 0 && c_or;
      vectors++;
      if (c_pend !== 1'(exp_c) || c_cr !== (exp_c == 0) || c_ov !== (exp_c != 0)) begin
        miscompares++;
        $display("FAIL depth1 cyc=%0d got pend=%0d cr=%b ov=%b want pend=%0d", cycles, c_pend, c_cr, c_ov, exp_c);
      end
      if (acc) begin
        sb.push_back(m_val);
        pushed++;
        m_val = m_val - 8'd1;
      end
      if (em) begin
        e = sb.pop_front();
        popped++;
        vectors++;
        if (c_outs !== e) begin
          miscompares++;
          $display("FAIL neg_step tok=%0d got %0d want %0d", popped, c_outs, e);
        end
      end
      exp_c += int'(acc) - int'(em);
      cycles++;
    end
    c_cv = 0;
    vectors++;
    if (popped != 3 || cycles != 6) begin
      miscompares++;
      $display("FAIL depth1_rate got emits=%0d cycles=%0d want 3 6", popped, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_latency_const();
    test_backpressure();
    test_back_to_back();
    test_seq_wrap();
    test_neg_step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
